// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: opcode/flag inputs and datapath controls of the multicycle MIPS controller.
interface multicycle_controller_if #(
    parameter int OPW = 6,
    parameter int FNW = 6
);
    logic [OPW-1:0] Op;
    logic [FNW-1:0] Funct;
    logic           Zero;
    logic           PCEn;
    logic           IorD;
    logic           MemWrite;
    logic           IRWrite;
    logic           RegDst;
    logic           MemtoReg;
    logic           RegWrite;
    logic           ALUSrcA;
    logic [1:0]     ALUSrcB;
    logic [1:0]     PCSrc;
    logic [2:0]     AluCon;
    logic           Illegal;
    logic [3:0]     State;

    modport master (
        input  Op, Funct, Zero,
        output PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSrc, AluCon, Illegal, State
    );

    modport slave (
        output Op, Funct, Zero,
        input  PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSrc, AluCon, Illegal, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM sequencing fetch/decode/execute/memory/writeback.
module multicycle_controller (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_controller_if.master bus
);
    localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

    logic [3:0] state_q, state_d, s;
    logic       pc_write, branch, mem_write, ir_write, reg_write, illegal;
    logic [2:0] funct_alu;
    logic       funct_ok;

    assign funct_alu = (bus.Funct == F_ADD) ? 3'b010 :
                       (bus.Funct == F_SUB) ? 3'b110 :
                       (bus.Funct == F_AND) ? 3'b000 :
                       (bus.Funct == F_OR)  ? 3'b001 :
                       (bus.Funct == F_SLT) ? 3'b111 : 3'b010;
    assign funct_ok  = bus.Funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};

    // In reset the selects follow FETCH so the datapath sees a clean fetch setup.
    assign s = rst_n ? state_q : S_FETCH;

    always_comb begin
        state_d     = S_FETCH;
        pc_write    = 1'b0;
        branch      = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        illegal     = 1'b0;
        bus.IorD    = 1'b0;
        bus.RegDst  = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.ALUSrcA = 1'b0;
        bus.ALUSrcB = 2'b00;
        bus.PCSrc   = 2'b00;
        bus.AluCon  = 3'b000;
        case (s)
            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                bus.AluCon  = 3'b010;
                case (bus.Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.AluCon  = 3'b010;
                state_d     = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.IorD = 1'b1;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write    = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                bus.IorD  = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.AluCon  = funct_alu;
                illegal     = !funct_ok;
                state_d     = funct_ok ? S_ALUWB : S_FETCH;
            end
            S_ALUWB: begin
                bus.RegDst = 1'b1;
                reg_write  = 1'b1;
            end
            S_BEQ: begin
                bus.ALUSrcA = 1'b1;
                bus.AluCon  = 3'b110;
                bus.PCSrc   = 2'b01;
                branch      = 1'b1;
            end
            S_ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.AluCon  = 3'b010;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_write  = 1'b1;
                bus.PCSrc = 2'b10;
            end
            default: begin
                ir_write    = 1'b1;
                pc_write    = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.AluCon  = 3'b010;
                state_d     = (s == S_FETCH) ? S_DECODE : S_FETCH;
            end
        endcase
    end

    assign bus.PCEn     = rst_n & (pc_write | (branch & bus.Zero));
    assign bus.MemWrite = rst_n & mem_write;
    assign bus.IRWrite  = rst_n & ir_write;
    assign bus.RegWrite = rst_n & reg_write;
    assign bus.Illegal  = rst_n & illegal;
    assign bus.State    = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: vector table, reset corner cases and random instruction streams vs. a reference model.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();
    multicycle_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic       pcen, iord, mw, irw, rd, m2r, rw, asa;
        logic [1:0] asb, pcs;
        logic [2:0] alu;
        logic       ill;
        logic [3:0] st;
    } out_t;

    typedef struct {
        string      nm;
        logic [5:0] op, fn;
        int         zm, ncyc, abort_at;
    } vec_t;

    int   checks = 0, failures = 0;
    out_t tbl [12];
    int   seq [$];
    vec_t vecs [$];
    logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    function automatic out_t mk(int st, bit pcen, iord, mw, irw, rd, m2r, rw, asa,
                                logic [1:0] asb, pcs, logic [2:0] alu);
        out_t r;
        r = '0;
        r.st = st[3:0]; r.pcen = pcen; r.iord = iord; r.mw = mw; r.irw = irw; r.rd = rd;
        r.m2r = m2r; r.rw = rw; r.asa = asa; r.asb = asb; r.pcs = pcs; r.alu = alu;
        return r;
    endfunction

    function automatic out_t sample();
        return out_t'({bus.PCEn, bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                       bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.AluCon, bus.Illegal, bus.State});
    endfunction

    function automatic bit fn_ok(logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic logic [2:0] fn_alu(logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    // Instruction-level model: which steps an instruction walks through.
    task automatic build_seq(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b100011: seq = '{0, 1, 2, 3, 4};
            6'b101011: seq = '{0, 1, 2, 5};
            6'b000000: seq = fn_ok(fn) ? '{0, 1, 6, 7} : '{0, 1, 6};
            6'b000100: seq = '{0, 1, 8};
            6'b001000: seq = '{0, 1, 9, 10};
            6'b000010: seq = '{0, 1, 11};
            default:   seq = '{0, 1};
        endcase
    endtask

    function automatic out_t model(int st, logic [5:0] op, logic [5:0] fn, logic z, output out_t m);
        out_t e;
        e = tbl[st];
        m = '1;
        if (st == 1) e.ill = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
        if (st == 6) begin
            e.ill = !fn_ok(fn);
            e.alu = fn_alu(fn);
            if (e.ill) m.alu = '0;
        end
        if (st == 8) e.pcen = z;
        return e;
    endfunction

    task automatic chk_out(input string nm, input out_t got, input out_t exp_o, input out_t msk);
        checks++;
        if (((got ^ exp_o) & msk) != '0) begin
            failures++;
            $display("FAIL %s got=%h exp=%h mask=%h", nm, got, exp_o, msk);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp_v);
        end
    endtask

    task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                             input int zm, input int ncyc, input int abort_at);
        int   n;
        out_t e, m;
        build_seq(op, fn);
        bus.Op = op;
        bus.Funct = fn;
        n = 0;
        forever begin
            bus.Zero = (zm == 2) ? 1'($urandom_range(1)) : zm[0];
            if (n == abort_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                e = tbl[0]; e.pcen = 1'b0; e.irw = 1'b0;
                m = '1; m.st = '0;
                chk_out({nm, " in_reset"}, sample(), e, m);
                @(posedge clk); #1;
                rst_n = 1'b1;
                chk_int({nm, " state_after_reset"}, int'(bus.State), 0);
                return;
            end
            e = model((n < seq.size()) ? seq[n] : 0, op, fn, bus.Zero, m);
            @(negedge clk);
            chk_out($sformatf("%s cyc%0d", nm, n), sample(), e, m);
            @(posedge clk); #1;
            n++;
            if (bus.State == 4'd0 || n >= 20) break;
        end
        chk_int({nm, " cycles"}, n, (ncyc >= 0) ? ncyc : seq.size());
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        out_t e, m;
        int   ab;
        logic [5:0] op, fn;
        tbl[0]  = mk(0,  1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010);
        tbl[1]  = mk(1,  0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010);
        tbl[2]  = mk(2,  0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010);
        tbl[3]  = mk(3,  0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000);
        tbl[4]  = mk(4,  0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b000);
        tbl[5]  = mk(5,  0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000);
        tbl[6]  = mk(6,  0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000);
        tbl[7]  = mk(7,  0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000);
        tbl[8]  = mk(8,  0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110);
        tbl[9]  = mk(9,  0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010);
        tbl[10] = mk(10, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000);
        tbl[11] = mk(11, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000);

        vecs.push_back('{"lw",       6'b100011, 6'b000000, 0, 5, -1});
        vecs.push_back('{"sw",       6'b101011, 6'b000000, 1, 4, -1});
        vecs.push_back('{"add",      6'b000000, 6'b100000, 0, 4, -1});
        vecs.push_back('{"sub",      6'b000000, 6'b100010, 1, 4, -1});
        vecs.push_back('{"and",      6'b000000, 6'b100100, 0, 4, -1});
        vecs.push_back('{"or",       6'b000000, 6'b100101, 0, 4, -1});
        vecs.push_back('{"slt",      6'b000000, 6'b101010, 1, 4, -1});
        vecs.push_back('{"bad_fn",   6'b000000, 6'b000111, 0, 3, -1});
        vecs.push_back('{"addi",     6'b001000, 6'b000000, 1, 4, -1});
        vecs.push_back('{"beq_z1",   6'b000100, 6'b000000, 1, 3, -1});
        vecs.push_back('{"beq_z0",   6'b000100, 6'b000000, 0, 3, -1});
        vecs.push_back('{"j",        6'b000010, 6'b000000, 1, 3, -1});
        vecs.push_back('{"bad_op",   6'b111111, 6'b100000, 0, 2, -1});
        vecs.push_back('{"sw_abort", 6'b101011, 6'b000000, 0, -1, 3});
        vecs.push_back('{"lw_abort", 6'b100011, 6'b000000, 1, -1, 2});
        vecs.push_back('{"beq_rst",  6'b000100, 6'b000000, 1, -1, 2});

        rst_n = 1'b0;
        bus.Op = 6'b100011;
        bus.Funct = 6'b000000;
        bus.Zero = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = tbl[0]; e.pcen = 1'b0; e.irw = 1'b0;
            m = '1; m.st = '0;
            chk_out($sformatf("reset%0d", i), sample(), e, m);
            @(posedge clk);
        end
        #1;
        rst_n = 1'b1;
        chk_int("state_after_reset", int'(bus.State), 0);

        foreach (vecs[i]) run_instr(vecs[i].nm, vecs[i].op, vecs[i].fn, vecs[i].zm, vecs[i].ncyc, vecs[i].abort_at);

        for (int i = 0; i < 300; i++) begin
            int k;
            k  = $urandom_range(6);
            op = (k == 6) ? 6'($urandom_range(63)) : ops[k];
            fn = ($urandom_range(3) != 0) ? fns[$urandom_range(4)] : 6'($urandom_range(63));
            build_seq(op, fn);
            ab = ($urandom_range(9) == 0) ? $urandom_range(seq.size() - 1) : -1;
            run_instr($sformatf("rnd%0d", i), op, fn, 2, -1, ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
